// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared register-bank widths and constants for the write arbiter
package regfile_wr_arbiter_pkg;

    localparam int CPU_DW    = 10;
    localparam int CPU_AW    = 3;
    localparam int CPU_NREGS = 2 ** CPU_AW;
    localparam int REG_ZERO  = 0;
    localparam int CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rtl/regfile_wr_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            win_valid
);

    always_comb begin
        int j;
        j         = 0;
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!win_valid && elig[j]) begin
                win_valid = 1'b1;
                win_idx   = PW'(j);
                win_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the single register-bank write port
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DW       = CPU_DW,
    parameter int AW       = CPU_AW,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [2**AW-1:0]     rf_wen,
    output logic [DW-1:0]        rf_d,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   win_oh;
    logic              win_valid;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_data;
    logic [2**AW-1:0]  wen_nxt;
    logic [PW-1:0]     ptr_nxt;
    logic              collide;

    // The current grantee is masked so a request held through its gnt cycle is not re-granted.
    assign elig = req & ~gnt;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .elig      (elig),
        .ptr       (ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign win_addr = req_addr[win_idx*AW +: AW];
    assign win_data = req_data[win_idx*DW +: DW];
    assign collide  = $countones(elig) >= 2;
    assign ptr_nxt  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        wen_nxt = '0;
        if (win_valid && !(ZERO_REG != 0 && win_addr == AW'(REG_ZERO))) begin
            wen_nxt[win_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt          <= '0;
            rf_wen       <= '0;
            rf_d         <= '0;
            conflict_cnt <= '0;
            ptr          <= '0;
        end else begin
            gnt    <= win_oh;
            rf_wen <= wen_nxt;
            if (win_valid) begin
                rf_d <= win_data;
                ptr  <= ptr_nxt;
            end
            if (collide && conflict_cnt != CNT_MAX) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int N  = 3;
    localparam int DW = 10;
    localparam int AW = 3;
    localparam int NR = 2 ** AW;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic [NR-1:0]     rf_wen;
    logic [DW-1:0]     rf_d;
    logic [7:0]        conflict_cnt;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]  m_gnt;
    logic [NR-1:0] m_wen;
    logic [DW-1:0] m_rfd;
    int            m_ptr;
    int            m_cnt;
    logic [DW-1:0] bank [NR];
    int            waitg [N];
    logic [DW-1:0] old0;

    regfile_wr_arbiter #(
        .NREQ     (N),
        .DW       (DW),
        .AW       (AW),
        .ZERO_REG (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .gnt          (gnt),
        .rf_wen       (rf_wen),
        .rf_d         (rf_d),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0;
        m_wen = '0;
        m_rfd = '0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock: predict from the rules, advance, then compare at the falling edge.
    task automatic step(input string tag);
        logic [N-1:0] elig;
        int w, best, d;
        logic [AW-1:0] a;
        elig = req & ~m_gnt;
        w    = -1;
        best = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (elig[i] && d < best) begin
                best = d;
                w    = i;
            end
        end
        if ($countones(elig) >= 2) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_gnt = '0;
        m_wen = '0;
        if (w >= 0) begin
            a        = req_addr[w*AW +: AW];
            m_gnt[w] = 1'b1;
            if (a != 0) m_wen[a] = 1'b1;
            m_rfd = req_data[w*DW +: DW];
            m_ptr = (w + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        chk({tag, ".wen"}, 32'(rf_wen), 32'(m_wen));
        chk({tag, ".rfd"}, 32'(rf_d), 32'(m_rfd));
        chk({tag, ".cnt"}, 32'(conflict_cnt), 32'(m_cnt));
        for (int k = 0; k < NR; k++) if (rf_wen[k]) bank[k] = rf_d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.wen", 32'(rf_wen), 0);
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        req      = '1;
        req_addr = '0;
        req_data = '0;
        for (int k = 0; k < NR; k++) bank[k] = '0;
        for (int i = 0; i < N; i++) waitg[i] = 0;
        model_reset();

        // reset held with all requests up
        repeat (3) begin
            @(negedge clk);
            chk("t1.gnt", 32'(gnt), 0);
            chk("t1.wen", 32'(rf_wen), 0);
            chk("t1.rfd", 32'(rf_d), 0);
            chk("t1.cnt", 32'(conflict_cnt), 0);
        end
        req = '0;
        rst = 1'b1;

        // single request
        set_req(1, 3'd5, 10'h2A5);
        step("t2");
        chk("t2.gnt_c", 32'(gnt), 32'b010);
        chk("t2.wen_c", 32'(rf_wen), 32'h20);
        chk("t2.rfd_c", 32'(rf_d), 32'h2A5);
        req = '0;
        step("t2idle");
        chk("t2.bank5", 32'(bank[5]), 32'h2A5);

        // round robin from ptr=0
        do_reset();
        set_req(0, 3'd1, DW'($urandom));
        set_req(1, 3'd2, DW'($urandom));
        set_req(2, 3'd4, DW'($urandom));
        step("t3a");
        chk("t3.g0", 32'(gnt), 32'b001);
        chk("t3.c1", 32'(conflict_cnt), 1);
        req[0] = 1'b0;
        step("t3b");
        chk("t3.g1", 32'(gnt), 32'b010);
        chk("t3.c2", 32'(conflict_cnt), 2);
        req[1] = 1'b0;
        step("t3c");
        chk("t3.g2", 32'(gnt), 32'b100);
        req[2] = 1'b0;
        step("t3idle");

        // zero register write is granted but suppressed
        old0 = bank[0];
        set_req(0, 3'd0, 10'h3FF);
        step("t4");
        chk("t4.gnt_c", 32'(gnt), 32'b001);
        chk("t4.wen_c", 32'(rf_wen), 0);
        req = '0;
        step("t4idle");
        chk("t4.bank0", 32'(bank[0]), 32'(old0));

        // same-address serialization
        do_reset();
        set_req(0, 3'd3, 10'h001);
        set_req(2, 3'd3, 10'h155);
        step("t5a");
        chk("t5.bank3a", 32'(bank[3]), 32'h001);
        req[0] = 1'b0;
        step("t5b");
        chk("t5.bank3b", 32'(bank[3]), 32'h155);
        req = '0;
        step("t5idle");

        // saturation, then asynchronous reset mid-grant
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'($urandom), DW'($urandom));
        for (int c = 0; c < 300; c++) step("t6");
        chk("t6.sat", 32'(conflict_cnt), 32'hFF);
        chk("t6.midgnt", 32'(gnt != 0), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6.rgnt", 32'(gnt), 0);
        chk("t6.rwen", 32'(rf_wen), 0);
        chk("t6.rcnt", 32'(conflict_cnt), 0);
        model_reset();
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step("t6post");
        chk("t6.lowest", 32'(gnt), 32'b010);
        req = '0;
        step("t6idle");

        // randomized traffic with starvation bound
        for (int c = 0; c < 600; c++) begin
            step("rnd");
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    chk("rnd.starve", 32'(waitg[i] <= N - 1), 1);
                    req[i] = 1'b0;
                end else if (req[i] && gnt != 0) begin
                    waitg[i]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !gnt[i] && ($urandom_range(0, 2) != 0)) begin
                    set_req(i, AW'($urandom), DW'($urandom));
                    waitg[i] = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
